// File: rtl/never8_pkg.sv
// Shared widths, reset/halt constants and the fetch entry type for the Never8 fetch path.
package never8_pkg;

    localparam int ADDR_W = 8;
    localparam int DATA_W = 8;
    localparam logic [ADDR_W-1:0] RESET_PC    = 8'h00;
    localparam logic [DATA_W-1:0] HALT_OPCODE = 8'hFF;

    typedef struct packed {
        logic [DATA_W-1:0] instr;
        logic [ADDR_W-1:0] pc;
    } fetch_entry_t;

endpackage

// File: rtl/fetch_unit_if.sv
// Program-memory and decoder-side bus of the fetch unit.
// master = fetch unit side, slave = memory/decoder side.
interface fetch_unit_if;
    import never8_pkg::*;

    logic [ADDR_W-1:0] mem_addr;
    logic [DATA_W-1:0] mem_data;
    logic [DATA_W-1:0] instr;
    logic [ADDR_W-1:0] instr_pc;
    logic              instr_valid;
    logic              instr_ready;
    logic              jump_en;
    logic [ADDR_W-1:0] jump_addr;
    logic              halted;

    modport master (
        output mem_addr,
        input  mem_data,
        output instr,
        output instr_pc,
        output instr_valid,
        input  instr_ready,
        input  jump_en,
        input  jump_addr,
        output halted
    );

    modport slave (
        input  mem_addr,
        output mem_data,
        input  instr,
        input  instr_pc,
        input  instr_valid,
        output instr_ready,
        output jump_en,
        output jump_addr,
        input  halted
    );

endinterface

// File: rtl/fetch_buffer.sv
// Two-entry synchronous FIFO of {instr, pc} with flush; head is driven straight from storage registers.
module fetch_buffer
    import never8_pkg::*;
(
    input  logic         clk,
    input  logic         rst,
    input  logic         push,
    input  fetch_entry_t push_entry,
    input  logic         pop,
    input  logic         flush,
    output logic [1:0]   count,
    output fetch_entry_t head,
    output logic         head_valid
);

    fetch_entry_t entries [2];
    logic         rd_ptr;
    logic         wr_ptr;
    logic         do_push;
    logic         do_pop;

    assign do_pop  = pop && (count != 2'd0);
    // A push into a full buffer is only legal when the head leaves in the same cycle.
    assign do_push = push && ((count != 2'd2) || do_pop);

    always_ff @(posedge clk) begin
        if (rst) begin
            entries[0] <= '0;
            entries[1] <= '0;
            rd_ptr     <= 1'b0;
            wr_ptr     <= 1'b0;
            count      <= 2'd0;
        end else if (flush) begin
            rd_ptr <= 1'b0;
            wr_ptr <= 1'b0;
            count  <= 2'd0;
        end else begin
            if (do_push) begin
                entries[wr_ptr] <= push_entry;
                wr_ptr          <= ~wr_ptr;
            end
            if (do_pop) begin
                rd_ptr <= ~rd_ptr;
            end
            count <= count + {1'b0, do_push} - {1'b0, do_pop};
        end
    end

    assign head       = entries[rd_ptr];
    assign head_valid = (count != 2'd0);

endmodule

// File: rtl/fetch_unit.sv
// Never8 instruction fetch: PC, issue control, in-flight tracking over a 1-cycle-latency memory.
// Optional halt-on-opcode behaviour is enabled with the FETCH_HALT_EN macro.
module fetch_unit
    import never8_pkg::*;
(
    input  logic        clk,
    input  logic        rst,
    fetch_unit_if.master bus
);

    logic [ADDR_W-1:0] pc;
    logic [ADDR_W-1:0] inflight_pc;
    logic              inflight;
    logic              halted;
    logic              pop;
    logic              push;
    logic              issue;
    logic [1:0]        count;
    logic [2:0]        occupancy;
    fetch_entry_t      push_entry;
    fetch_entry_t      head;
    logic              head_valid;

    assign pop       = head_valid && bus.instr_ready;
    // Slots already claimed after this edge's pop; the returning word always has a home.
    assign occupancy = {1'b0, count} + {2'b00, inflight} - {2'b00, pop};
    assign issue     = !bus.jump_en && !halted && (occupancy < 3'd2);
    assign push      = inflight && !bus.jump_en;
    assign push_entry = fetch_entry_t'({bus.mem_data, inflight_pc});

    always_ff @(posedge clk) begin
        if (rst) begin
            pc          <= RESET_PC;
            inflight    <= 1'b0;
            inflight_pc <= '0;
        end else if (bus.jump_en) begin
            pc       <= bus.jump_addr;
            inflight <= 1'b0;
        end else begin
            inflight <= issue;
            if (issue) begin
                inflight_pc <= pc;
                pc          <= pc + 1'b1;
            end
        end
    end

`ifdef FETCH_HALT_EN
    // Halt latches when the halt opcode lands in the buffer; a redirect restarts fetch.
    always_ff @(posedge clk) begin
        if (rst) begin
            halted <= 1'b0;
        end else if (bus.jump_en) begin
            halted <= 1'b0;
        end else if (inflight && (bus.mem_data == HALT_OPCODE)) begin
            halted <= 1'b1;
        end
    end
`else
    assign halted = 1'b0;
`endif

    fetch_buffer u_buf (
        .clk       (clk),
        .rst       (rst),
        .push      (push),
        .push_entry(push_entry),
        .pop       (pop),
        .flush     (bus.jump_en),
        .count     (count),
        .head      (head),
        .head_valid(head_valid)
    );

    assign bus.mem_addr    = pc;
    assign bus.instr       = head.instr;
    assign bus.instr_pc    = head.pc;
    assign bus.instr_valid = head_valid;
    assign bus.halted      = halted;

endmodule

// File: tb/tb_fetch_unit.sv
// Self-checking bench for fetch_unit: directed scenarios plus a randomized stream
// checked against an in-order program-sequence model.
module tb_fetch_unit;
    import never8_pkg::*;

    logic clk = 1'b0;
    logic rst;
    int   checks = 0;
    int   errors = 0;
    int   overflow_events = 0;
    logic [DATA_W-1:0] memory [256];

    fetch_unit_if bus ();

    fetch_unit dut (
        .clk(clk),
        .rst(rst),
        .bus(bus)
    );

    always #5 clk = ~clk;

    // Synchronous-read program memory: address captured at the edge, data returned for the next cycle.
    always @(posedge clk) bus.mem_data <= memory[bus.mem_addr];

    always @(posedge clk) begin
        if (!rst && dut.u_buf.push && (dut.u_buf.count == 2'd2) && !dut.u_buf.pop)
            overflow_events <= overflow_events + 1;
    end

    task automatic tick();
        @(negedge clk);
    endtask

    task automatic restart_stream();
        rst = 1'b1;
        bus.jump_en = 1'b0;
        tick();
        rst = 1'b0;
    endtask

    task automatic fill_memory();
        for (int i = 0; i < 256; i++) memory[i] = 8'($urandom_range(0, 254));
        memory[0] = 8'h01;
        memory[1] = 8'h02;
        memory[2] = 8'h03;
    endtask

    task automatic test_reset();
        fill_memory();
        rst = 1'b1;
        bus.instr_ready = 1'b1;
        bus.jump_en = 1'b0;
        bus.jump_addr = '0;
        tick();
        tick();
        checks++;
        if (bus.instr_valid !== 1'b0) begin errors++; $display("[TB] FAIL reset_valid: got %b expected 0", bus.instr_valid); end
        checks++;
        if ({bus.instr, bus.instr_pc} !== 16'h0000) begin errors++; $display("[TB] FAIL reset_head: got %h/%h expected 00/00", bus.instr, bus.instr_pc); end
        checks++;
        if (bus.mem_addr !== RESET_PC) begin errors++; $display("[TB] FAIL reset_addr: got %h expected %h", bus.mem_addr, RESET_PC); end
        checks++;
        if (bus.halted !== 1'b0) begin errors++; $display("[TB] FAIL reset_halted: got %b expected 0", bus.halted); end
    endtask

    task automatic test_startup();
        rst = 1'b0;
        tick();
        checks++;
        if (bus.instr_valid !== 1'b0) begin errors++; $display("[TB] FAIL startup_latency: valid %b one cycle after release, expected 0", bus.instr_valid); end
        checks++;
        if (bus.mem_addr !== RESET_PC + 8'd1) begin errors++; $display("[TB] FAIL startup_addr: got %h expected %h", bus.mem_addr, RESET_PC + 8'd1); end
        tick();
        for (int k = 0; k < 3; k++) begin
            checks++;
            if ({bus.instr_valid, bus.instr, bus.instr_pc} !== {1'b1, 8'(k + 1), 8'(k)})
            begin
                errors++;
                $display("[TB] FAIL startup_seq%0d: got v=%b %h@%h expected v=1 %h@%h",
                         k, bus.instr_valid, bus.instr, bus.instr_pc, 8'(k + 1), 8'(k));
            end
            tick();
        end
    endtask

    task automatic test_stall();
        bus.instr_ready = 1'b1;
        restart_stream();
        tick();
        tick();
        bus.instr_ready = 1'b0;
        for (int k = 0; k < 5; k++) begin
            tick();
            checks++;
            if ({bus.instr_valid, bus.instr, bus.instr_pc, bus.mem_addr} !== {1'b1, 8'h01, 8'h00, 8'h02}) begin
                errors++;
                $display("[TB] FAIL stall_hold%0d: got v=%b %h@%h addr=%h expected v=1 01@00 addr=02",
                         k, bus.instr_valid, bus.instr, bus.instr_pc, bus.mem_addr);
            end
        end
        bus.instr_ready = 1'b1;
        for (int k = 1; k < 3; k++) begin
            tick();
            checks++;
            if ({bus.instr_valid, bus.instr, bus.instr_pc} !== {1'b1, 8'(k + 1), 8'(k)}) begin
                errors++;
                $display("[TB] FAIL stall_release%0d: got v=%b %h@%h expected v=1 %h@%h",
                         k, bus.instr_valid, bus.instr, bus.instr_pc, 8'(k + 1), 8'(k));
            end
        end
    endtask

    task automatic test_jump_flush();
        bus.instr_ready = 1'b1;
        restart_stream();
        tick();
        tick();
        bus.instr_ready = 1'b0;
        bus.jump_en = 1'b1;
        bus.jump_addr = 8'h80;
        tick();
        bus.jump_en = 1'b0;
        bus.instr_ready = 1'b1;
        checks++;
        if ({bus.instr_valid, bus.mem_addr} !== {1'b0, 8'h80}) begin
            errors++;
            $display("[TB] FAIL jump_flush: got v=%b addr=%h expected v=0 addr=80", bus.instr_valid, bus.mem_addr);
        end
        tick();
        checks++;
        if (bus.instr_valid !== 1'b0) begin errors++; $display("[TB] FAIL jump_stale: got valid %b expected 0", bus.instr_valid); end
        tick();
        checks++;
        if ({bus.instr_valid, bus.instr, bus.instr_pc} !== {1'b1, memory[8'h80], 8'h80}) begin
            errors++;
            $display("[TB] FAIL jump_target: got v=%b %h@%h expected v=1 %h@80",
                     bus.instr_valid, bus.instr, bus.instr_pc, memory[8'h80]);
        end
    endtask

    task automatic test_wrap();
        logic [ADDR_W-1:0] exp_pc;
        bus.instr_ready = 1'b1;
        bus.jump_en = 1'b1;
        bus.jump_addr = 8'hFE;
        tick();
        bus.jump_en = 1'b0;
        tick();
        exp_pc = 8'hFE;
        for (int k = 0; k < 4; k++) begin
            tick();
            checks++;
            if ({bus.instr_valid, bus.instr, bus.instr_pc} !== {1'b1, memory[exp_pc], exp_pc}) begin
                errors++;
                $display("[TB] FAIL wrap%0d: got v=%b %h@%h expected v=1 %h@%h",
                         k, bus.instr_valid, bus.instr, bus.instr_pc, memory[exp_pc], exp_pc);
            end
            exp_pc = exp_pc + 8'd1;
        end
    endtask

    task automatic test_mid_reset();
        checks++;
        if (bus.instr_valid !== 1'b1) begin errors++; $display("[TB] FAIL midreset_pre: got valid %b expected 1", bus.instr_valid); end
        rst = 1'b1;
        tick();
        rst = 1'b0;
        checks++;
        if ({bus.instr_valid, bus.mem_addr, bus.instr, bus.instr_pc} !== {1'b0, RESET_PC, 8'h00, 8'h00}) begin
            errors++;
            $display("[TB] FAIL midreset_clear: got v=%b addr=%h %h@%h expected v=0 addr=%h 00@00",
                     bus.instr_valid, bus.mem_addr, bus.instr, bus.instr_pc, RESET_PC);
        end
        tick();
        checks++;
        if (bus.instr_valid !== 1'b0) begin errors++; $display("[TB] FAIL midreset_latency: got valid %b expected 0", bus.instr_valid); end
        for (int k = 0; k < 3; k++) begin
            tick();
            checks++;
            if ({bus.instr_valid, bus.instr, bus.instr_pc} !== {1'b1, 8'(k + 1), 8'(k)}) begin
                errors++;
                $display("[TB] FAIL midreset_seq%0d: got v=%b %h@%h expected v=1 %h@%h",
                         k, bus.instr_valid, bus.instr, bus.instr_pc, 8'(k + 1), 8'(k));
            end
        end
    endtask

    task automatic test_halt();
        logic [ADDR_W-1:0] hold_addr;
        memory[3] = HALT_OPCODE;
        memory[4] = 8'h44;
        bus.instr_ready = 1'b1;
        restart_stream();
        for (int k = 0; k < 5; k++) tick();
        checks++;
        if ({bus.instr_valid, bus.instr, bus.instr_pc} !== {1'b1, HALT_OPCODE, 8'h03}) begin
            errors++;
            $display("[TB] FAIL halt_deliver: got v=%b %h@%h expected v=1 %h@03",
                     bus.instr_valid, bus.instr, bus.instr_pc, HALT_OPCODE);
        end
`ifdef FETCH_HALT_EN
        checks++;
        if (bus.halted !== 1'b1) begin errors++; $display("[TB] FAIL halt_flag: got %b expected 1", bus.halted); end
        tick();
        hold_addr = bus.mem_addr;
        for (int k = 0; k < 4; k++) begin
            tick();
            checks++;
            if ({bus.halted, bus.mem_addr} !== {1'b1, hold_addr}) begin
                errors++;
                $display("[TB] FAIL halt_hold%0d: got halted=%b addr=%h expected halted=1 addr=%h",
                         k, bus.halted, bus.mem_addr, hold_addr);
            end
        end
        checks++;
        if (bus.instr_valid !== 1'b0) begin errors++; $display("[TB] FAIL halt_drain: got valid %b expected 0", bus.instr_valid); end
        bus.jump_en = 1'b1;
        bus.jump_addr = 8'h00;
        tick();
        bus.jump_en = 1'b0;
        checks++;
        if (bus.halted !== 1'b0) begin errors++; $display("[TB] FAIL halt_clear: got %b expected 0", bus.halted); end
        tick();
        tick();
        checks++;
        if ({bus.instr_valid, bus.instr, bus.instr_pc} !== {1'b1, 8'h01, 8'h00}) begin
            errors++;
            $display("[TB] FAIL halt_refetch: got v=%b %h@%h expected v=1 01@00", bus.instr_valid, bus.instr, bus.instr_pc);
        end
`else
        checks++;
        if (bus.halted !== 1'b0) begin errors++; $display("[TB] FAIL halt_disabled: got %b expected 0", bus.halted); end
        tick();
        checks++;
        if ({bus.instr_valid, bus.instr, bus.instr_pc, bus.halted} !== {1'b1, 8'h44, 8'h04, 1'b0}) begin
            errors++;
            $display("[TB] FAIL halt_ignored: got v=%b %h@%h halted=%b expected v=1 44@04 halted=0",
                     bus.instr_valid, bus.instr, bus.instr_pc, bus.halted);
        end
`endif
        memory[3] = 8'h10;
    endtask

    // Reference model: the program order is target, target+1, ... after each redirect,
    // and valid must be steady from two cycles after the redirect onwards.
    task automatic test_random_stream();
        logic [ADDR_W-1:0] exp_pc;
        logic [ADDR_W-1:0] jaddr;
        int  since;
        bit  rst_i, jump_i, ready_i;
        fill_memory();
        exp_pc = RESET_PC;
        since  = 0;
        for (int cyc = 0; cyc < 1500; cyc++) begin
            rst_i   = (cyc == 0) || ($urandom_range(0, 99) == 0);
            jump_i  = !rst_i && ($urandom_range(0, 24) == 0);
            jaddr   = 8'($urandom);
            ready_i = ($urandom_range(0, 3) != 0);
            if (cyc > 0) begin
                checks++;
                if ({bus.instr_valid, bus.halted} !== {since >= 2, 1'b0}) begin
                    errors++;
                    $display("[TB] FAIL rand_valid cyc%0d: got v=%b halted=%b expected v=%b halted=0",
                             cyc, bus.instr_valid, bus.halted, since >= 2);
                end
                if (bus.instr_valid && ready_i) begin
                    checks++;
                    if ({bus.instr, bus.instr_pc} !== {memory[exp_pc], exp_pc}) begin
                        errors++;
                        $display("[TB] FAIL rand_order cyc%0d: got %h@%h expected %h@%h",
                                 cyc, bus.instr, bus.instr_pc, memory[exp_pc], exp_pc);
                    end
                    exp_pc = exp_pc + 8'd1;
                end
            end
            rst = rst_i;
            bus.jump_en = jump_i;
            bus.jump_addr = jaddr;
            bus.instr_ready = ready_i;
            if (rst_i) begin
                exp_pc = RESET_PC;
                since  = 0;
            end else if (jump_i) begin
                exp_pc = jaddr;
                since  = 0;
            end else if (since < 2) begin
                since++;
            end
            tick();
        end
        rst = 1'b0;
        bus.jump_en = 1'b0;
        tick();
        checks++;
        if (overflow_events != 0) begin errors++; $display("[TB] FAIL buffer_overflow: got %0d events expected 0", overflow_events); end
    endtask

    initial begin
        rst = 1'b1;
        bus.instr_ready = 1'b1;
        bus.jump_en = 1'b0;
        bus.jump_addr = '0;
        $display("[TB] starting fetch_unit bench");
        test_reset();
        test_startup();
        test_stall();
        test_jump_flush();
        test_wrap();
        test_mid_reset();
        test_halt();
        test_random_stream();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
